ibex_rf_write_buffer: RTL and testbench

IBEX_RF_WRITE_BUFFER -- requirements
Module: ibex_rf_write_buffer

---
 rtl/ibex_rf_write_buffer.sv | 113 +++++++++++
 tb/tb_ibex_rf_write_buffer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_rf_write_buffer.sv
// Register-file write buffer: in-order FIFO between writeback and the RF write
// port, forwarding the youngest pending value to two decode read ports.
module ibex_rf_write_buffer #(
    parameter int DataWidth = 32,
    parameter int Depth     = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    wb_we_i,
    input  logic [4:0]              wb_waddr_i,
    input  logic [DataWidth-1:0]    wb_wdata_i,
    output logic                    wb_stall_o,
    output logic                    rf_we_o,
    output logic [4:0]              rf_waddr_o,
    output logic [DataWidth-1:0]    rf_wdata_o,
    input  logic                    rf_wready_i,
    input  logic [4:0]              raddr_a_i,
    input  logic [4:0]              raddr_b_i,
    output logic                    fwd_a_valid_o,
    output logic                    fwd_b_valid_o,
    output logic [DataWidth-1:0]    fwd_a_data_o,
    output logic [DataWidth-1:0]    fwd_b_data_o,
    output logic                    empty_o,
    output logic [$clog2(Depth):0]  level_o
);
    localparam int PW = $clog2(Depth);
    typedef logic [PW-1:0] ptr_t;

    logic [4:0]           r_addr [Depth];
    logic [DataWidth-1:0] r_data [Depth];
    logic [Depth-1:0]     r_valid;
    ptr_t                 r_wptr;
    ptr_t                 r_rptr;
    logic [PW:0]          r_count;

    logic                 w_full;
    logic                 w_req;
    logic                 w_enq;
    logic                 w_deq;
    ptr_t                 w_idx;
    logic [4:0]           w_raddr [2];
    logic [1:0]           w_fvalid;
    logic [DataWidth-1:0] w_fdata [2];

    assign empty_o    = (r_count == '0);
    assign level_o    = r_count;
    assign w_full     = (r_count == (PW+1)'(Depth));
    assign rf_we_o    = !empty_o;
    assign w_deq      = rf_we_o & rf_wready_i;
    assign w_req      = wb_we_i & (wb_waddr_i != 5'd0);
    assign wb_stall_o = w_full & !w_deq & w_req;
    assign w_enq      = w_req & !wb_stall_o;

    // Head fields are gated so stale storage never leaks after reset.
    assign rf_waddr_o = rf_we_o ? r_addr[r_rptr] : '0;
    assign rf_wdata_o = rf_we_o ? r_data[r_rptr] : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_deq) begin
                r_valid[r_rptr] <= 1'b0;
                r_rptr          <= r_rptr + 1'b1;
            end
            if (w_enq) begin
                r_valid[r_wptr] <= 1'b1;
                r_wptr          <= r_wptr + 1'b1;
            end
            if (w_enq && !w_deq) begin
                r_count <= r_count + 1'b1;
            end else if (!w_enq && w_deq) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_addr[r_wptr] <= wb_waddr_i;
            r_data[r_wptr] <= wb_wdata_i;
        end
    end

    assign w_raddr[0] = raddr_a_i;
    assign w_raddr[1] = raddr_b_i;

    // Walk oldest to youngest from the read pointer; later hits win.
    always_comb begin
        w_idx = '0;
        for (int p = 0; p < 2; p++) begin
            w_fvalid[p] = 1'b0;
            w_fdata[p]  = '0;
            for (int k = 0; k < Depth; k++) begin
                w_idx = r_rptr + ptr_t'(k);
                if (r_valid[w_idx] && (w_raddr[p] != 5'd0) &&
                    (r_addr[w_idx] == w_raddr[p])) begin
                    w_fvalid[p] = 1'b1;
                    w_fdata[p]  = r_data[w_idx];
                end
            end
        end
    end

    assign fwd_a_valid_o = w_fvalid[0];
    assign fwd_b_valid_o = w_fvalid[1];
    assign fwd_a_data_o  = w_fdata[0];
    assign fwd_b_data_o  = w_fdata[1];

endmodule

// File: tb/tb_ibex_rf_write_buffer.sv
// Self-checking bench for ibex_rf_write_buffer: vector table, directed
// corner sequences, and random traffic against a queue-based model.
module tb_ibex_rf_write_buffer;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst_ni;
    logic          we;
    logic [4:0]    waddr;
    logic [DW-1:0] wdata;
    logic          wready;
    logic [4:0]    ra;
    logic [4:0]    rb;
    logic          stall;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          fa_v;
    logic          fb_v;
    logic [DW-1:0] fa_d;
    logic [DW-1:0] fb_d;
    logic          empty;
    logic [2:0]    level;

    ibex_rf_write_buffer #(.DataWidth(DW), .Depth(DEPTH)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .wb_we_i      (we),
        .wb_waddr_i   (waddr),
        .wb_wdata_i   (wdata),
        .wb_stall_o   (stall),
        .rf_we_o      (rf_we),
        .rf_waddr_o   (rf_waddr),
        .rf_wdata_o   (rf_wdata),
        .rf_wready_i  (wready),
        .raddr_a_i    (ra),
        .raddr_b_i    (rb),
        .fwd_a_valid_o(fa_v),
        .fwd_b_valid_o(fb_v),
        .fwd_a_data_o (fa_d),
        .fwd_b_data_o (fb_d),
        .empty_o      (empty),
        .level_o      (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]    a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t q[$];
    ent_t acc_log[$];
    ent_t rf_log[$];

    int   total = 0;
    int   bad   = 0;
    logic m_deq;
    logic m_req;
    logic m_stall;

    typedef struct {
        logic          we;
        logic [4:0]    a;
        logic [DW-1:0] d;
        logic          wr;
        logic [4:0]    ra;
        logic [4:0]    rb;
        logic          stall;
        logic          rfwe;
        logic [4:0]    rwa;
        logic [DW-1:0] rwd;
        logic          fav;
        logic [DW-1:0] fad;
        logic          fbv;
        logic [DW-1:0] fbd;
        logic [2:0]    lvl;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic we_, input logic [4:0] a_, input logic [DW-1:0] d_,
        input logic wr_, input logic [4:0] ra_, input logic [4:0] rb_,
        input logic st_, input logic rfwe_, input logic [4:0] rwa_,
        input logic [DW-1:0] rwd_, input logic fav_, input logic [DW-1:0] fad_,
        input logic fbv_, input logic [DW-1:0] fbd_, input logic [2:0] lvl_);
        vec_t v;
        v.we = we_;  v.a = a_;  v.d = d_;  v.wr = wr_;
        v.ra = ra_;  v.rb = rb_;
        v.stall = st_;  v.rfwe = rfwe_;  v.rwa = rwa_;  v.rwd = rwd_;
        v.fav = fav_;  v.fad = fad_;  v.fbv = fbv_;  v.fbd = fbd_;
        v.lvl = lvl_;
        return v;
    endfunction

    // Newest pending value for a register, from the model queue.
    task automatic model_fwd(input logic [4:0] r, output logic v,
                             output logic [DW-1:0] d);
        v = 1'b0;
        d = '0;
        if (r != 5'd0) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].a == r) begin
                    v = 1'b1;
                    d = q[i].d;
                    break;
                end
            end
        end
    endtask

    // Drive inputs, let them settle, compare every output to the model.
    task automatic step(input logic we_, input logic [4:0] a_,
                        input logic [DW-1:0] d_, input logic wr_,
                        input logic [4:0] ra_, input logic [4:0] rb_);
        logic          ev;
        logic [DW-1:0] ed;
        int            sz;
        ent_t          e;
        we = we_;  waddr = a_;  wdata = d_;  wready = wr_;
        ra = ra_;  rb = rb_;
        #1;
        sz      = q.size();
        m_deq   = (sz != 0) && wr_;
        m_req   = we_ && (a_ != 5'd0);
        m_stall = (sz == DEPTH) && !m_deq && m_req;
        chk("m_rf_we", 64'(rf_we), 64'(sz != 0));
        chk("m_rf_waddr", 64'(rf_waddr), (sz != 0) ? 64'(q[0].a) : 64'd0);
        chk("m_rf_wdata", 64'(rf_wdata), (sz != 0) ? 64'(q[0].d) : 64'd0);
        chk("m_stall", 64'(stall), 64'(m_stall));
        chk("m_empty", 64'(empty), 64'(sz == 0));
        chk("m_level", 64'(level), 64'(sz));
        model_fwd(ra_, ev, ed);
        chk("m_fwd_a_v", 64'(fa_v), 64'(ev));
        chk("m_fwd_a_d", 64'(fa_d), 64'(ed));
        model_fwd(rb_, ev, ed);
        chk("m_fwd_b_v", 64'(fb_v), 64'(ev));
        chk("m_fwd_b_d", 64'(fb_d), 64'(ed));
        if (rf_we && wr_) begin
            e.a = rf_waddr;
            e.d = rf_wdata;
            rf_log.push_back(e);
        end
    endtask

    task automatic tick();
        ent_t e;
        @(posedge clk);
        if (rst_ni) begin
            if (m_deq) void'(q.pop_front());
            if (m_req && !m_stall) begin
                e.a = waddr;
                e.d = wdata;
                q.push_back(e);
                acc_log.push_back(e);
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        rst_ni = 1'b0;
        q.delete();
        step(1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd0);
        tick();
        rst_ni = 1'b1;
        rf_log.delete();
        acc_log.delete();
    endtask

    initial begin
        rst_ni = 1'b0;
        m_deq = 1'b0;  m_req = 1'b0;  m_stall = 1'b0;
        #3;
        step(1'b1, 5'd3, 32'h1234, 1'b1, 5'd3, 5'd3);
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        tick();
        rst_ni = 1'b1;

        tbl[0]  = mk(0, 5'd0, 32'h0, 1, 5'd0, 5'd0,
                     0, 0, 5'd0, 32'h0, 0, 32'h0, 0, 32'h0, 3'd0);
        tbl[1]  = mk(1, 5'd5, 32'hAAAA0001, 1, 5'd5, 5'd0,
                     0, 0, 5'd0, 32'h0, 0, 32'h0, 0, 32'h0, 3'd0);
        tbl[2]  = mk(0, 5'd0, 32'h0, 1, 5'd5, 5'd0,
                     0, 1, 5'd5, 32'hAAAA0001, 1, 32'hAAAA0001, 0, 32'h0, 3'd1);
        tbl[3]  = mk(0, 5'd0, 32'h0, 1, 5'd5, 5'd0,
                     0, 0, 5'd0, 32'h0, 0, 32'h0, 0, 32'h0, 3'd0);
        tbl[4]  = mk(1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 5'd0,
                     0, 0, 5'd0, 32'h0, 0, 32'h0, 0, 32'h0, 3'd0);
        tbl[5]  = mk(0, 5'd0, 32'h0, 0, 5'd0, 5'd0,
                     0, 0, 5'd0, 32'h0, 0, 32'h0, 0, 32'h0, 3'd0);
        tbl[6]  = mk(1, 5'd7, 32'h11, 0, 5'd7, 5'd0,
                     0, 0, 5'd0, 32'h0, 0, 32'h0, 0, 32'h0, 3'd0);
        tbl[7]  = mk(1, 5'd7, 32'h22, 0, 5'd7, 5'd0,
                     0, 1, 5'd7, 32'h11, 1, 32'h11, 0, 32'h0, 3'd1);
        tbl[8]  = mk(0, 5'd0, 32'h0, 0, 5'd7, 5'd0,
                     0, 1, 5'd7, 32'h11, 1, 32'h22, 0, 32'h0, 3'd2);
        tbl[9]  = mk(0, 5'd0, 32'h0, 1, 5'd7, 5'd0,
                     0, 1, 5'd7, 32'h11, 1, 32'h22, 0, 32'h0, 3'd2);
        tbl[10] = mk(0, 5'd0, 32'h0, 1, 5'd7, 5'd0,
                     0, 1, 5'd7, 32'h22, 1, 32'h22, 0, 32'h0, 3'd1);
        tbl[11] = mk(0, 5'd0, 32'h0, 1, 5'd7, 5'd0,
                     0, 0, 5'd0, 32'h0, 0, 32'h0, 0, 32'h0, 3'd0);

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].wr,
                 tbl[i].ra, tbl[i].rb);
            chk($sformatf("t%0d_stall", i), 64'(stall), 64'(tbl[i].stall));
            chk($sformatf("t%0d_rfwe", i), 64'(rf_we), 64'(tbl[i].rfwe));
            chk($sformatf("t%0d_rwa", i), 64'(rf_waddr), 64'(tbl[i].rwa));
            chk($sformatf("t%0d_rwd", i), 64'(rf_wdata), 64'(tbl[i].rwd));
            chk($sformatf("t%0d_fav", i), 64'(fa_v), 64'(tbl[i].fav));
            chk($sformatf("t%0d_fad", i), 64'(fa_d), 64'(tbl[i].fad));
            chk($sformatf("t%0d_fbv", i), 64'(fb_v), 64'(tbl[i].fbv));
            chk($sformatf("t%0d_fbd", i), 64'(fb_d), 64'(tbl[i].fbd));
            chk($sformatf("t%0d_lvl", i), 64'(level), 64'(tbl[i].lvl));
            chk($sformatf("t%0d_empty", i), 64'(empty),
                64'(tbl[i].lvl == 3'd0));
            tick();
        end

        // Full buffer: stall, then accept while the head drains.
        apply_reset();
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 5'(i), 32'h100 + 32'(i), 1'b0, 5'd0, 5'd0);
            tick();
        end
        step(1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd0);
        chk("full_level", 64'(level), 64'd4);
        tick();
        step(1'b1, 5'd6, 32'h606, 1'b0, 5'd6, 5'd0);
        chk("full_stall", 64'(stall), 64'd1);
        tick();
        step(1'b1, 5'd6, 32'h606, 1'b1, 5'd6, 5'd0);
        chk("full_accept", 64'(stall), 64'd0);
        tick();
        step(1'b0, 5'd0, '0, 1'b1, 5'd6, 5'd0);
        chk("full_level_held", 64'(level), 64'd4);
        chk("full_fwd_new", 64'(fa_d), 64'h606);
        tick();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 5'd0, '0, 1'b1, 5'd0, 5'd0);
            tick();
        end
        chk("drain_count", 64'(rf_log.size()), 64'd5);
        begin
            logic [4:0] exp_order [5];
            exp_order = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd6};
            for (int i = 0; i < 5 && i < rf_log.size(); i++)
                chk($sformatf("drain_order%0d", i), 64'(rf_log[i].a),
                    64'(exp_order[i]));
        end

        // Wrap the pointers, then reset in the middle of a drain.
        apply_reset();
        for (int i = 1; i <= 3; i++) begin
            step(1'b1, 5'(i), 32'h200 + 32'(i), 1'b0, 5'd0, 5'd0);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 5'd0, '0, 1'b1, 5'd0, 5'd0);
            tick();
        end
        for (int i = 10; i <= 12; i++) begin
            step(1'b1, 5'(i), 32'h300 + 32'(i), 1'b0, 5'd0, 5'd0);
            tick();
        end
        step(1'b0, 5'd0, '0, 1'b1, 5'd11, 5'd12);
        chk("wrap_level", 64'(level), 64'd4);
        chk("wrap_fwd_b", 64'(fb_d), 64'h30C);
        tick();
        rst_ni = 1'b0;
        q.delete();
        step(1'b1, 5'd13, 32'h13, 1'b1, 5'd11, 5'd12);
        chk("mid_rst_rf_we", 64'(rf_we), 64'd0);
        chk("mid_rst_level", 64'(level), 64'd0);
        chk("mid_rst_fwd_a", 64'(fa_v), 64'd0);
        chk("mid_rst_stall", 64'(stall), 64'd0);
        tick();
        rst_ni = 1'b1;
        rf_log.delete();
        step(1'b1, 5'd9, 32'h99, 1'b1, 5'd0, 5'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 5'd0, '0, 1'b1, 5'd9, 5'd0);
            tick();
        end
        chk("post_rst_count", 64'(rf_log.size()), 64'd1);
        if (rf_log.size() > 0)
            chk("post_rst_addr", 64'(rf_log[0].a), 64'd9);

        // Random traffic; a stalled request is held by upstream.
        apply_reset();
        m_stall = 1'b0;
        begin
            logic          r_we;
            logic [4:0]    r_a;
            logic [DW-1:0] r_d;
            int            mism;
            r_we = 1'b0;  r_a = '0;  r_d = '0;
            for (int c = 0; c < 10000; c++) begin
                if (!m_stall) begin
                    r_we = 1'($urandom_range(0, 1));
                    r_a  = 5'($urandom_range(0, 7));
                    r_d  = $urandom;
                end
                step(r_we, r_a, r_d, 1'($urandom_range(0, 1)),
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
                tick();
            end
            for (int i = 0; i < DEPTH + 2; i++) begin
                step(1'b0, 5'd0, '0, 1'b1, 5'd0, 5'd0);
                tick();
            end
            chk("rand_seq_len", 64'(rf_log.size()), 64'(acc_log.size()));
            mism = 0;
            for (int i = 0; i < rf_log.size() && i < acc_log.size(); i++)
                if (rf_log[i] != acc_log[i]) mism++;
            chk("rand_seq_order", 64'(mism), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
